reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before any reset release.
REQ-002 SHALL have parameter PERIPH_TO_SYS_CYCLES, default 16: cycles from periph_reset release to sys_reset release.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536: consecutive stable samples needed to change debounced button level.
REQ-004 SHALL have port clk, input, 1 bit: 25 MHz board clock, the same free-running clock that feeds the PLL input, never a PLL output.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to clk.
REQ-007 SHALL have port btn_reset, input, 1 bit: raw user reset button, active-high, asynchronous, bouncing.
REQ-008 SHALL have port periph_reset, output, 1 bit: active-high reset for peripherals (video, SD, UART).
REQ-009 SHALL have port sys_reset, output, 1 bit: active-high reset for the CPU core.
REQ-010 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-011 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-012 SHALL have port lock_loss_count, output, 8 bits: saturating count of lock losses in RUN.

Function
REQ-013 SHALL pass pll_locked and btn_reset each through a 2-flop synchronizer (lock_s, btn_s), adding 2 cycles of latency.
REQ-014 SHALL set debounced level btn_lvl to 1 after DEBOUNCE_CYCLES consecutive btn_s=1 and to 0 after DEBOUNCE_CYCLES consecutive btn_s=0; any opposite sample restarts the count.
REQ-015 SHALL generate btn_req as a one-cycle pulse on the 0->1 transition of btn_lvl.
REQ-016 SHALL implement states WAIT_LOCK=0, STABLE=1, PERIPH=2, RUN=3; encodings 4-7 unused and SHALL go to WAIT_LOCK.
REQ-017 WAIT_LOCK: go to STABLE, with stable counter cleared, when lock_s=1 and btn_lvl=0; otherwise remain.
REQ-018 STABLE: counter increments each cycle; go to PERIPH on the cycle the counter equals LOCK_STABLE_CYCLES-1.
REQ-019 PERIPH: periph_reset=0; counter increments; go to RUN on the cycle the counter equals PERIPH_TO_SYS_CYCLES-1.
REQ-020 RUN: periph_reset=0, sys_reset=0, ready=1.
REQ-021 In STABLE, PERIPH or RUN, lock_s=0 or btn_req=1 SHALL force WAIT_LOCK on the next edge; this has priority over every other transition.
REQ-022 Outputs SHALL be registered and decoded from the next state, so resets reassert on the same edge that enters WAIT_LOCK.
REQ-023 periph_reset SHALL be 1 in WAIT_LOCK and STABLE; sys_reset SHALL be 1 in all states except RUN.
REQ-024 lock_loss_count SHALL increment on a RUN->WAIT_LOCK transition with lock_s=0 (including when btn_req coincides) and SHALL saturate at 255.
REQ-025 The counter SHALL be $clog2 of the larger cycle parameter bits wide and SHALL never wrap within a state.
REQ-026 A held button SHALL keep the block in WAIT_LOCK until btn_lvl returns to 0; it SHALL not retrigger while held.

Reset
REQ-027 reset=1 SHALL asynchronously set state=WAIT_LOCK, periph_reset=1, sys_reset=1, ready=0, lock_loss_count=0, counters=0, synchronizer flops=0, btn_lvl=0.
REQ-028 Reset mid-sequence SHALL restart from WAIT_LOCK with no partial release.

Structure
REQ-029 A shared package SHALL hold the state enum and the 3-bit state width constant.
REQ-030 The synchronizer plus debouncer SHALL be one sub-module, btn_debounce, which outputs btn_lvl and btn_req.

Verification (LOCK_STABLE_CYCLES=8, PERIPH_TO_SYS_CYCLES=4, DEBOUNCE_CYCLES=4)
REQ-031 pll_locked 0->1 and held -> periph_reset falls 2+1+8 cycles later; sys_reset and ready change 4 cycles after that; state reads 3.
REQ-032 pll_locked glitches low for 1 cycle mid-STABLE -> return to WAIT_LOCK, full 8-cycle count restarts, lock_loss_count stays 0.
REQ-033 In RUN, drop pll_locked 300 times -> both resets reassert each time; lock_loss_count=255 with no wrap.
REQ-034 Button bounces 1-3 cycles -> no reset; held 20 cycles in RUN -> resets reassert once, held in WAIT_LOCK until released and debounced, then sequence completes.
REQ-035 Assert reset during PERIPH -> all outputs reach reset values without a clock edge, lock_loss_count=0.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding for the board reset sequencer.
package reset_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    PERIPH    = 3'd2,
    RUN       = 3'd3
  } state_t;

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// Button synchronizer + debouncer: btn_lvl follows the button once it has held
// a new level for DEBOUNCE_CYCLES samples; btn_req pulses as btn_lvl rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_reset,
  output logic btn_lvl,
  output logic btn_req
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            btn_meta;
  logic            btn_s;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn_reset;
      btn_s    <= btn_meta;
    end
  end

  // db_cnt counts consecutive samples that disagree with the current level;
  // the level flips on the sample that completes the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt  <= '0;
      btn_lvl <= 1'b0;
      btn_req <= 1'b0;
    end else begin
      btn_req <= 1'b0;
      if (btn_s == btn_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt  <= '0;
        btn_lvl <= btn_s;
        btn_req <= btn_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases periph_reset after a stable PLL lock, then sys_reset a fixed delay
// later; lock loss or a debounced button press drops straight back to WAIT_LOCK.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES   = 1024,
  parameter int PERIPH_TO_SYS_CYCLES = 16,
  parameter int DEBOUNCE_CYCLES      = 65536
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               btn_reset,
  output logic               periph_reset,
  output logic               sys_reset,
  output logic               ready,
  output logic [STATE_W-1:0] state,
  output logic [7:0]         lock_loss_count
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > PERIPH_TO_SYS_CYCLES) ?
                           LOCK_STABLE_CYCLES : PERIPH_TO_SYS_CYCLES;
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_TO_SYS_CYCLES - 1);

  logic             lock_meta;
  logic             lock_s;
  logic             btn_lvl;
  logic             btn_req;
  logic             abort;
  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_reset(btn_reset),
    .btn_lvl  (btn_lvl),
    .btn_req  (btn_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  assign abort = !lock_s || btn_req;

  // Falling through to the WAIT_LOCK default is the abort path for every state.
  always_comb begin
    state_nxt = WAIT_LOCK;
    cnt_nxt   = '0;
    case (state_q)
      WAIT_LOCK: if (lock_s && !btn_lvl) state_nxt = STABLE;
      STABLE: begin
        if (!abort) begin
          if (cnt_q == STABLE_LAST) begin
            state_nxt = PERIPH;
          end else begin
            state_nxt = STABLE;
            cnt_nxt   = cnt_q + 1'b1;
          end
        end
      end
      PERIPH: begin
        if (!abort) begin
          if (cnt_q == PERIPH_LAST) begin
            state_nxt = RUN;
          end else begin
            state_nxt = PERIPH;
            cnt_nxt   = cnt_q + 1'b1;
          end
        end
      end
      RUN:     if (!abort) state_nxt = RUN;
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Outputs decode state_nxt so resets reassert on the edge that aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      periph_reset    <= 1'b1;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      periph_reset <= (state_nxt != PERIPH) && (state_nxt != RUN);
      sys_reset    <= (state_nxt != RUN);
      ready        <= (state_nxt == RUN);
      if ((state_q == RUN) && !lock_s && (lock_loss_count != 8'hFF))
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short cycle parameters (8/4/4).
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       btn_reset;
  logic       periph_reset;
  logic       sys_reset;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_loss_count;

  int checks;
  int errors;
  int exp_llc;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES  (8),
    .PERIPH_TO_SYS_CYCLES(4),
    .DEBOUNCE_CYCLES     (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .btn_reset      (btn_reset),
    .periph_reset   (periph_reset),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .state          (state),
    .lock_loss_count(lock_loss_count)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_llc    = 0;
    reset      = 1'b1;
    pll_locked = 1'b0;
    btn_reset  = 1'b0;
    tick(3);
    check("rst_periph", periph_reset, 1);
    check("rst_sys", sys_reset, 1);
    check("rst_ready", ready, 0);
    check("rst_state", state, 0);
    check("rst_llc", lock_loss_count, 0);
    reset = 1'b0;
    tick(4);
    check("nolock_state", state, 0);

    // Lock rises: periph release at edge 11, sys release at edge 15.
    pll_locked = 1'b1;
    tick(10);
    check("seq_e10_periph", periph_reset, 1);
    check("seq_e10_state", state, 1);
    tick(1);
    check("seq_e11_periph", periph_reset, 0);
    check("seq_e11_sys", sys_reset, 1);
    check("seq_e11_state", state, 2);
    tick(3);
    check("seq_e14_sys", sys_reset, 1);
    check("seq_e14_ready", ready, 0);
    tick(1);
    check("seq_e15_sys", sys_reset, 0);
    check("seq_e15_ready", ready, 1);
    check("seq_e15_state", state, 3);
    check("seq_llc", lock_loss_count, 0);

    reset = 1'b1;
    #2;
    check("async_state", state, 0);
    check("async_sys", sys_reset, 1);
    tick(1);
    reset = 1'b0;

    // One-cycle lock glitch in STABLE restarts the whole stable count.
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    check("glitch_state", state, 0);
    check("glitch_periph", periph_reset, 1);
    tick(1);
    check("glitch_restart", state, 1);
    tick(7);
    check("glitch_e16_state", state, 1);
    tick(1);
    check("glitch_e17_state", state, 2);
    check("glitch_e17_periph", periph_reset, 0);
    tick(4);
    check("glitch_run", ready, 1);
    check("glitch_llc", lock_loss_count, 0);

    // Repeated lock losses from RUN; counter saturates.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(2);
      if (exp_llc < 255) exp_llc++;
      check("loss_periph", periph_reset, 1);
      check("loss_sys", sys_reset, 1);
      check("loss_state", state, 0);
      check("loss_llc", lock_loss_count, exp_llc);
      tick(13);
      check("loss_rerun", ready, 1);
    end
    check("loss_llc_sat", lock_loss_count, 255);

    // Short bounces are filtered.
    for (int k = 1; k <= 3; k++) begin
      btn_reset = 1'b1;
      tick(k);
      btn_reset = 1'b0;
      tick(8);
      check("bounce_ready", ready, 1);
      check("bounce_state", state, 3);
    end

    // Held button: one abort, held in WAIT_LOCK until debounced release.
    btn_reset = 1'b1;
    tick(6);
    check("btn_e6_ready", ready, 1);
    tick(1);
    check("btn_e7_ready", ready, 0);
    check("btn_e7_sys", sys_reset, 1);
    check("btn_e7_periph", periph_reset, 1);
    check("btn_e7_state", state, 0);
    tick(13);
    check("btn_held_state", state, 0);
    btn_reset = 1'b0;
    tick(6);
    check("btn_rel_e26_state", state, 0);
    tick(1);
    check("btn_rel_e27_state", state, 1);
    tick(12);
    check("btn_rerun_ready", ready, 1);
    check("btn_rerun_state", state, 3);
    check("btn_llc", lock_loss_count, 255);

    // Reset asserted while in PERIPH.
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    tick(9);
    check("mid_state_periph", state, 2);
    check("mid_periph_rel", periph_reset, 0);
    #4;
    reset = 1'b1;
    #2;
    check("mid_rst_periph", periph_reset, 1);
    check("mid_rst_sys", sys_reset, 1);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_llc", lock_loss_count, 0);
    tick(2);
    reset = 1'b0;
    tick(10);
    check("restart_e10_periph", periph_reset, 1);
    check("restart_e10_state", state, 1);
    tick(1);
    check("restart_e11_state", state, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
